serial_adder_seq: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/half_adder_cell.sv | 12 +
 rtl/serial_adder_seq.sv | 123 ++++++++++++
 tb/tb_serial_adder_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Optional subtract mode: define SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single-bit half adder; two of these plus an OR form one full-adder slice.
module half_adder_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial LSB-first adder, one bit per enabled clock.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port for a - b.
module serial_adder_seq
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  res;
    logic [WIDTH-1:0]  res_next;
    logic              carry;
    logic [CW-1:0]     count;
    logic              last;
    logic              sub_i;
    logic              p;
    logic              g0;
    logic              g1;
    logic              s_bit;
    logic              cn;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_i = sub;
`else
    assign sub_i = 1'b0;
`endif

    half_adder_cell ha_ab (
        .x (a_sh[0]),
        .y (b_sh[0]),
        .s (p),
        .c (g0)
    );

    half_adder_cell ha_pc (
        .x (p),
        .y (carry),
        .s (s_bit),
        .c (g1)
    );

    assign cn       = g0 | g1;
    assign last     = (count == LAST);
    assign res_next = {s_bit, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Result is published only on the final shift so it stays stable in SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (ena) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= sub_i ? ~b : b;
                        carry <= sub_i;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= res_next;
                    carry <= cn;
                    count <= count + 1'b1;
                    if (last) begin
                        sum  <= res_next;
                        cout <= cn;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE) && ena;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq: directed vectors, decoupled monitor.
module tb_serial_adder_seq;

    localparam int W = 8;

    typedef struct {
        logic [W:0] val;
        int         due;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    exp_t sb[$];
    int   rcyc;
    int   checks;
    int   passes;
    logic prev_done;

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial rcyc = 0;
    always @(posedge clk) rcyc = rcyc + 1;

    task automatic check(input string name, input logic [W+1:0] act,
                         input logic [W+1:0] req);
        checks = checks + 1;
        if (act === req) passes = passes + 1;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Monitor: pops one expectation per done pulse and checks value/timing.
    initial begin
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                check("done_single", {9'b0, prev_done}, '0);
                if (sb.size() == 0) begin
                    check("unexpected_done", {1'b0, cout, sum}, '1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", {1'b0, cout, sum}, {1'b0, e.val});
                    check("latency", (W+2)'(rcyc), (W+2)'(e.due));
                end
            end else if (sb.size() != 0 && rcyc > sb[0].due) begin
                exp_t e;
                e = sb.pop_front();
                check("done_timeout", (W+2)'(rcyc), (W+2)'(e.due));
            end
            prev_done = done;
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vs, input logic [W:0] exp,
                          input int stall);
        exp_t e;
        a     = va;
        b     = vb;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = vs;
`endif
        start = 1'b1;
        e.val = exp;
        e.due = rcyc + 1 + W + stall;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {9'b0, busy}, 10'd1);
        if (stall != 0) begin
            repeat (2) @(posedge clk);
            #1;
            ena = 1'b0;
            repeat (stall) @(posedge clk);
            #1;
            check("done_low_ena0", {9'b0, done}, '0);
            ena = 1'b1;
        end
        wait_drain();
    endtask

    initial begin
        exp_t e;
        checks = 0;
        passes = 0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {busy, done, cout, sum[6:0]}, '0);
        check("reset_sum", {2'b0, sum}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(8'h0F, 8'h01, 1'b0, 9'h010, 0);
        run_op(8'hFF, 8'h01, 1'b0, 9'h100, 0);
        run_op(8'h00, 8'h00, 1'b0, 9'h000, 0);

        // Held start: second request only accepted once back in IDLE.
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        e.val = 9'h046;
        e.due = rcyc + 1 + W;
        sb.push_back(e);
        e.val = 9'h1FE;
        e.due = rcyc + 11 + W;
        sb.push_back(e);
        @(posedge clk);
        #1;
        a = 8'hFF;
        b = 8'hFF;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();

        // Abandon an op with async reset mid-shift.
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy_done", {8'b0, busy, done}, '0);
        check("rst_mid_sum", {1'b0, cout, sum}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        run_op(8'hAA, 8'h55, 1'b0, 9'h0FF, 0);

        run_op(8'h3C, 8'hC4, 1'b0, 9'h100, 3);
        run_op(8'h81, 8'h7E, 1'b0, 9'h0FF, 0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, 9'h0FE, 0);
        run_op(8'h07, 8'h05, 1'b1, 9'h102, 0);
`endif

        check("scoreboard_empty", (W+2)'(sb.size()), '0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
